md5_padder: RTL
===============

# md5_padder

Byte-stream front end for the `MD5` core. It accepts message bytes over a valid/ready handshake and packs them little-endian into 512-bit blocks. It applies standard MD5 padding: a 0x80 byte, zero fill, and the 64-bit little-endian bit length. Finished blocks go out on the `message` bus layout the core consumes, so upstream logic no longer has to pre-pad messages.

## Interface

Parameters:
- `LEN_W`, default 32: width of the internal byte counter. The bit length is `{count, 3'b000}` zero-extended to 64 bits.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  message byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  qualifies the final byte of a message; sampled only on an accept.
- `in_ready`  out  1  the padder can take a byte.
- `blk_data`  out  512  padded block. Byte k sits at bits [8k+7:8k], so word w = bits [32w+31:32w] matches `message[w]`.
- `blk_valid`  out  1  `blk_data` holds a complete block.
- `blk_ready`  in  1  the consumer takes the block.
- `blk_first`  out  1  the block is the first block of its message; the core reinitialises its chaining state.
- `blk_last`  out  1  the block is the final block of its message; the digest is valid after it.

## Operation

- States:
  - ACCUM: collecting bytes, `in_ready`=1.
  - HOLD: non-final block presented.
  - HOLD_LAST: final block presented.
- Accept = `in_valid && in_ready`. Accepted byte goes to byte position `idx`. Then `idx` increments mod 64 and `count` increments mod 2^LEN_W.
- Accept with `in_last`=0:
  - If `idx`=63, go to HOLD.
  - Otherwise stay in ACCUM.
- Accept with `in_last`=1. Let p = number of bytes used in the block after this byte (1..64):
  - p ≤ 55: byte p = 0x80, bytes p+1..55 = 0, bytes 56..63 = bit length. Go to HOLD_LAST.
  - 56 ≤ p ≤ 63: byte p = 0x80, remaining bytes = 0. Set `pad2`=1 and `need80`=0. Go to HOLD.
  - p = 64: block is raw data. Set `pad2`=1 and `need80`=1. Go to HOLD.
- HOLD and HOLD_LAST when `blk_ready`=1 (transfer):
  - HOLD with `pad2`=1: load the extra block. Byte 0 = 0x80 if `need80`, else 0. All other bytes 0, except bytes 56..63 = bit length. Clear `pad2` and go to HOLD_LAST.
  - HOLD with `pad2`=0: clear the buffer, set `idx`=0, go to ACCUM.
  - HOLD_LAST: clear the buffer, set `idx`=0 and `count`=0, set `first_pend`=1, go to ACCUM.
- `blk_first` = `first_pend` for the block being presented. `first_pend` clears on that block's transfer.
- `blk_last` = (state == HOLD_LAST).
- Length field: bit length = `count` × 8, taken from `count` after the last byte, mod 2^64. It is stored little-endian: low word in word 14, high word in word 15.
- Zero-length messages are unsupported; every message carries at least one byte with `in_last`.
- Buffer bytes not yet written are always 0. Because the buffer is cleared on each block transfer, a raw-data-only block never carries stale bytes.

## Timing

- Reset: state=ACCUM, `idx`=0, `count`=0, buffer=0, `pad2`=0, `need80`=0, `first_pend`=1. Outputs during and after reset:
  - `blk_valid`=0, `blk_first`=0, `blk_last`=0, `blk_data`=0.
  - `in_ready` = (state==ACCUM) && !`reset`, so it is 0 while `reset` is high.
- Reset mid-message or mid-block drops all partial data. No block is emitted for it.
- `blk_valid` rises the cycle after the accept that completes a block. `blk_valid` = (state != ACCUM).
- `in_ready`=0 in HOLD and HOLD_LAST, so no byte is lost while a block waits.
- While `blk_valid && !blk_ready`, the following hold stable: `blk_data`, `blk_first`, `blk_last`.
- An extra pad block appears the cycle after the preceding transfer, with `blk_valid` held high. ACCUM resumes the cycle after the final transfer.
- Sustained throughput: 64 bytes per 65 cycles with `blk_ready` tied high.
- `count` wraps silently at 2^LEN_W bytes.

## Test plan

- 55-byte ASCII "Hello ENPM808! This is my MD5 implementation in verilog", no backpressure. Expect one block with `blk_first`=`blk_last`=1:
  - word0=0x6c6c6548, word1=0x4e45206f, word13=0x80676f6c, word14=0x000001b8, word15=0.
  - Remaining words are the packed text.
- Single byte 0x61 with `in_last`. Expect one block: word0=0x00008061, word14=0x00000008, all other words 0, `blk_first`=`blk_last`=1.
- 56 bytes of 0x00. Expect two blocks:
  - Block 1: word14=0x00000080, all other words 0, `blk_first`=1, `blk_last`=0.
  - Block 2: word14=0x000001c0, all other words 0, `blk_first`=0, `blk_last`=1.
- 64 bytes of 0xff. Expect two blocks:
  - Block 1: all ones, `blk_last`=0.
  - Block 2: word0=0x00000080, word14=0x00000200, `blk_last`=1.
- Backpressure: hold `blk_ready`=0 for 5 cycles on block 1 of the 56-byte case. Expect `blk_data`, `blk_first` and `blk_last` stable, `in_ready`=0 throughout, and block 2 the cycle after the transfer.
- Reset after 10 bytes, then the single-byte 0x61 message. Expect output identical to the single-byte case (`count` cleared, `blk_first`=1).

Source files
------------

// File: rtl/md5_padder.sv
// md5_padder
//   Byte-stream front end for the MD5 core. Accepts message bytes over a
//   valid/ready handshake, packs them little-endian into 512-bit blocks and
//   applies MD5 padding (0x80, zero fill, 64-bit little-endian bit length).
//   An extra pad block is emitted when the length field does not fit.
//
// Ports
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high
//   in_data    : message byte
//   in_valid   : in_data is valid
//   in_last    : in_data is the final byte of its message (sampled on accept)
//   in_ready   : padder can take a byte
//   blk_data   : padded block, byte k at bits [8k+7:8k]
//   blk_valid  : blk_data holds a complete block
//   blk_ready  : consumer takes the block
//   blk_first  : block is the first of its message
//   blk_last   : block is the final one of its message
module md5_padder #(
   parameter int LEN_W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [511:0] blk_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic         blk_first,
   output logic         blk_last
);

   typedef enum logic [1:0] {ACCUM, HOLD, HOLD_LAST} state_t;

   state_t             state;
   logic [5:0]         idx;
   logic [LEN_W-1:0]   count;
   logic [511:0]       buffer;
   logic               pad2;
   logic               need80;
   logic               first_pend;

   logic [LEN_W-1:0]   count_n;
   logic [6:0]         p_pos;
   logic [511:0]       fill_blk;
   logic               accept;

   // Bit length of a message of c bytes, truncated to the 64-bit field.
   function automatic logic [63:0] bit_len(input logic [LEN_W-1:0] c);
      logic [63:0] w;
      w = 64'(c);
      return w << 3;
   endfunction

   assign in_ready  = (state == ACCUM) && !reset;
   assign accept    = in_valid && in_ready;
   assign blk_valid = !reset && (state != ACCUM);
   assign blk_first = blk_valid && first_pend;
   assign blk_last  = !reset && (state == HOLD_LAST);
   assign blk_data  = reset ? '0 : buffer;

   assign count_n = count + 1'b1;
   // Bytes used in the block once the current byte lands (1..64).
   assign p_pos   = {1'b0, idx} + 7'd1;

   // Block contents after writing the current byte, including the padding
   // marker and length field when this byte closes the message.
   always_comb begin
      // NOTE: every variable driven here gets a full default first so no latch is inferred.
      fill_blk = buffer;
      fill_blk[{idx, 3'b000} +: 8] = in_data;
      if (in_last) begin
         if (p_pos != 7'd64) fill_blk[{p_pos[5:0], 3'b000} +: 8] = 8'h80;
         if (p_pos <= 7'd55) fill_blk[511:448] = bit_len(count_n);
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      if (reset) begin
         state      <= ACCUM;
         idx        <= '0;
         count      <= '0;
         buffer     <= '0;
         pad2       <= 1'b0;
         need80     <= 1'b0;
         first_pend <= 1'b1;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  buffer <= fill_blk;
                  idx    <= idx + 6'd1;
                  count  <= count_n;
                  if (!in_last) begin
                     if (idx == 6'd63) state <= HOLD;
                  end else if (p_pos <= 7'd55) begin
                     state <= HOLD_LAST;
                  end else begin
                     // Length does not fit: a second block carries it.
                     pad2   <= 1'b1;
                     need80 <= (p_pos == 7'd64);
                     state  <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (blk_ready) begin
                  first_pend <= 1'b0;
                  if (pad2) begin
                     buffer <= {bit_len(count), 440'd0, (need80 ? 8'h80 : 8'h00)};
                     pad2   <= 1'b0;
                     state  <= HOLD_LAST;
                  end else begin
                     buffer <= '0;
                     idx    <= '0;
                     state  <= ACCUM;
                  end
               end
            end
            HOLD_LAST: begin
               if (blk_ready) begin
                  buffer     <= '0;
                  idx        <= '0;
                  count      <= '0;
                  first_pend <= 1'b1;
                  state      <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule
